// File: rtl/tick_ser_pkg.sv
// Shared types and line levels for the tick-paced serializer.
// Optional macro TICK_SER_PARITY_EN adds the even-parity bit state.
package tick_ser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TICK_SER_PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_END
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Bit index width, kept at least one bit so a 1-bit payload still builds.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/tick_ser_shreg.sv
// Payload shift register and bit index for tick_serializer (LSB first).
// Optional macro TICK_SER_PARITY_EN adds a parity bit captured at load.
module tick_ser_shreg
  import tick_ser_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef TICK_SER_PARITY_EN
  output logic              parity_o,
`endif
  output logic              bit_o,
  output logic              last_o
);

  localparam int IDX_W = idx_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    if (load_i) begin
      data_d = data_i;
      idx_d  = '0;
    end else if (shift_i) begin
      data_d = data_q >> 1;
      // Park at zero after the last bit instead of counting past DATA_W-1.
      idx_d  = last_o ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

`ifdef TICK_SER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (load_i) parity_q <= ^data_i;
  end

  assign parity_o = parity_q;
`endif

  assign bit_o  = data_q[0];
  assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/tick_serializer.sv
// Frames a payload word as start/data/[parity]/stop bits, one bit per tick.
// Optional macro TICK_SER_PARITY_EN inserts an even-parity bit after the data.
module tick_serializer
  import tick_ser_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;
  logic   ser_q, ser_d;
  logic   done_q, done_d;
  logic   load, shift;
  logic   sh_bit, sh_last;
`ifdef TICK_SER_PARITY_EN
  logic   sh_par;
`endif

  tick_ser_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .shift_i  (shift),
    .data_i   (in_data),
`ifdef TICK_SER_PARITY_EN
    .parity_o (sh_par),
`endif
    .bit_o    (sh_bit),
    .last_o   (sh_last)
  );

  always_comb begin
    state_d = state_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      // Acceptance ignores tick so the start bit always waits a full bit time.
      S_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          ser_d   = START_LEVEL;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          ser_d = sh_bit;
          shift = 1'b1;
          if (sh_last) begin
`ifdef TICK_SER_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef TICK_SER_PARITY_EN
      S_PAR: begin
        if (tick) begin
          ser_d   = sh_par;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          ser_d   = IDLE_LEVEL;
          state_d = S_END;
        end
      end
      S_END: begin
        if (tick) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ser_q   <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = ~in_ready;
  assign ser_out  = ser_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tick_serializer.sv
// Directed scoreboard bench for tick_serializer; follows TICK_SER_PARITY_EN if defined.
module tb_tick_serializer;

  localparam int DATA_W = 8;
`ifdef TICK_SER_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FT = DATA_W + 3 + PAR_EN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ser_out;
  logic              busy;
  logic              done;

  int   checks   = 0;
  int   failures = 0;
  bit   exp_q[$];
  logic line_exp = 1'b1;

  tick_serializer #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line value after each tick of a frame, END tick included.
  task automatic push_frame(input logic [DATA_W-1:0] w);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) exp_q.push_back(w[i]);
    if (PAR_EN != 0) exp_q.push_back(^w);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
  endtask

  task automatic accept(input logic [DATA_W-1:0] w, input logic tick_same,
                        input logic hold, input logic [DATA_W-1:0] alt);
    check("ready_before_accept", in_ready, 1'b1);
    in_data  = w;
    in_valid = 1'b1;
    tick     = tick_same;
    step();
    tick = 1'b0;
    if (hold) in_data = alt;
    else      in_valid = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    check("ready_after_accept", in_ready, 1'b0);
    check("line_after_accept", ser_out, 1'b1);
    line_exp = 1'b1;
    push_frame(w);
  endtask

  task automatic run_ticks(input int period, input int n, input int total,
                           input logic keep_valid);
    logic e;
    for (int k = 1; k <= n; k++) begin
      for (int c = 1; c < period; c++) begin
        tick = 1'b0;
        step();
        check("line_hold_between_ticks", ser_out, line_exp);
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (k == total) in_valid = keep_valid;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 1'bx;
      line_exp = e;
      check("ser_bit", ser_out, e);
      check("done_timing", done, (k == total));
      if (k == total) check("ready_at_done", in_ready, 1'b1);
    end
  endtask

  task automatic full_frame(input logic [DATA_W-1:0] w);
    accept(w, 1'b0, 1'b0, '0);
    run_ticks(4, FT, FT, 1'b0);
    step();
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    tick     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    check("rst_ser_out", ser_out, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Ticks while idle leave the line alone.
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_tick_line", ser_out, 1'b1);
      check("idle_tick_ready", in_ready, 1'b1);
      check("idle_tick_done", done, 1'b0);
    end
    tick = 1'b0;
    step();

    full_frame(8'hA5);
    full_frame(8'h07);

    // Back-to-back: valid held; second word offered during the first frame.
    accept(8'h3C, 1'b0, 1'b1, 8'hC3);
    run_ticks(4, FT, FT, 1'b1);
    accept(8'hC3, 1'b0, 1'b0, '0);
    run_ticks(4, FT, FT, 1'b0);
    step();
    check("b2b_done_one_cycle", done, 1'b0);

    // Tick coinciding with acceptance is ignored.
    accept(8'h96, 1'b1, 1'b0, '0);
    run_ticks(4, FT, FT, 1'b0);
    step();

    // Tick every cycle with junk offered while busy.
    accept(8'hFF, 1'b0, 1'b1, 8'h00);
    run_ticks(1, FT, FT, 1'b0);
    step();
    check("fast_done_one_cycle", done, 1'b0);

    // Asynchronous reset during data bit 4.
    accept(8'hE0, 1'b0, 1'b0, '0);
    run_ticks(4, 6, FT, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ser_out", ser_out, 1'b1);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick = (i % 4 == 3);
      step();
      check("post_rst_no_done", done, 1'b0);
      check("post_rst_line", ser_out, 1'b1);
    end
    tick = 1'b0;
    full_frame(8'hC5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_serializer.md
TICK_SERIALIZER -- requirements
Module: tick_serializer

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  one-cycle bit strobe from the upstream 4-cycle pulse generator; advances the frame by one bit time.
REQ-005 in_data  input  DATA_W  payload word.
REQ-006 in_valid  input  1  payload offered.
REQ-007 in_ready  output  1  block can accept payload; high only in IDLE.
REQ-008 ser_out  output  1  serial line, registered, idle level 1.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PAR, STOP, END.
REQ-012 In IDLE with in_valid=1, the block SHALL latch in_data on the clk edge and enter START; a tick in that same cycle SHALL be ignored.
REQ-013 ser_out and the state SHALL change only on cycles with tick=1, except for acceptance (REQ-012) and reset.
REQ-014 On tick, transitions SHALL be:
  - START: ser_out<=0, go to DATA with index 0.
  - DATA: ser_out<=data[index], index+1; after index DATA_W-1, go to PAR (if enabled) else STOP.
  - PAR: ser_out<=parity, go to STOP.
  - STOP: ser_out<=1, go to END.
  - END: go to IDLE and pulse done.
REQ-015 Data SHALL be sent LSB first; the bit index counter SHALL be clog2(DATA_W) bits wide and SHALL NOT wrap mid-frame.
REQ-016 Frame length from acceptance to done SHALL be DATA_W+3 ticks (DATA_W+4 with parity).
REQ-017 done SHALL assert in the cycle after the END tick, simultaneous with in_ready=1; payload accepted in that cycle SHALL start a new frame with no idle bit time.
REQ-018 in_valid while busy SHALL be ignored; the latched word SHALL be unaffected.
REQ-019 tick while in IDLE SHALL have no effect; ser_out SHALL remain 1.
REQ-020 tick asserted on consecutive cycles SHALL advance one bit per cycle.

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, ser_out=1, busy=0, done=0, in_ready=1, and clear the index, including mid-frame.
REQ-022 The first acceptance after reset release SHALL behave as in REQ-012.

Configuration
REQ-023 Macro TICK_SER_PARITY_EN defined: PAR state present; parity bit = XOR of the latched data (even parity).
REQ-024 Macro absent: no PAR state and no parity logic; DATA goes directly to STOP.

Structure
REQ-025 Package tick_ser_pkg SHALL hold the state enum and the constants IDLE_LEVEL=1 and START_LEVEL=0.
REQ-026 Sub-module tick_ser_shreg SHALL hold the data shift register and bit index; the FSM stays in tick_serializer.

Verification (tick every 4 cycles unless stated)
REQ-027 Reset, send 0xA5 without parity -> ser_out ticks 0,1,0,1,0,0,1,0,1,1; done one cycle after the 11th tick.
REQ-028 Parity build, send 0x07 -> parity bit 1 at the 10th tick; stop bit at the 11th; done after the 12th.
REQ-029 in_valid held with 0x3C then 0xC3 -> second word accepted on the done cycle; start bit at the next tick; no extra 1 bit between frames.
REQ-030 Acceptance on the same cycle as tick -> that tick ignored; start bit appears at the following tick.
REQ-031 rst_n pulsed low during data bit 4 -> ser_out=1 and in_ready=1 with no clock; no done pulse.
REQ-032 tick every cycle, send 0xFF -> frame completes in 11 consecutive cycles; in_valid while busy is ignored.
